// File: rtl/pwm_beep_gen_pkg.sv
// ---------------------------------------------------------------------------
// pwm_beep_gen_pkg
//   Shared definitions for the buzzer PWM generator.
//   PWM_CNT_W : default width of period, pulse and the PWM counter. The
//               frequency-to-period converter uses the same width.
//   ST_*      : FSM state encodings, also visible on the fsm_state port.
// ---------------------------------------------------------------------------
package pwm_beep_gen_pkg;

    localparam int PWM_CNT_W = 26;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/pwm_beep_gen_shadow_cnt.sv
// ---------------------------------------------------------------------------
// pwm_beep_gen_shadow_cnt
//   Double-buffered period/pulse registers plus the PWM cycle counter.
//   The shadows change only when 'load' is high. The FSM raises 'load' on the
//   start of a tone and on a wrap while playing. A period or pulse change in
//   the middle of a cycle therefore cannot shorten the pulse in progress.
// Ports
//   clk, rst_n  in   clock, asynchronous active-low reset
//   active      in   1 while the FSM is in RUN or DRAIN (counter runs)
//   load        in   copy period/pulse into the shadow registers
//   period      in   CNT_W  requested PWM period
//   pulse       in   CNT_W  requested high time
//   cnt         out  CNT_W  position within the current PWM cycle
//   pulse_sh    out  CNT_W  high time of the current cycle
//   wrap        out  1 on the last clock of a PWM cycle (combinational)
// ---------------------------------------------------------------------------
module pwm_beep_gen_shadow_cnt
    import pwm_beep_gen_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pulse,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] pulse_sh,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] period_sh;

    // period_sh is never 0 while active, so period_sh - 1 cannot underflow
    // in any case that matters. In IDLE the result is masked by 'active'.
    assign wrap = active && (cnt == (period_sh - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh <= '0;
            pulse_sh  <= '0;
        end else if (load) begin
            period_sh <= period;
            pulse_sh  <= pulse;
        end
    end

    // The counter sits at 0 in IDLE, so a new tone starts at position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pwm_beep_gen.sv
// ---------------------------------------------------------------------------
// pwm_beep_gen
//   Buzzer PWM driver. It takes the period/pulse pair from the
//   frequency-to-period converter. A tone starts when en is high and the
//   period is non-zero. A tone stops only at a PWM cycle boundary, so the
//   buzzer never sees a runt pulse.
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   en         in   1 = play tone, 0 = stop at end of current cycle
//   period     in   CNT_W  PWM period in sys_clk cycles
//   pulse      in   CNT_W  high time in sys_clk cycles
//   beep_out   out  registered PWM output
//   cyc_done   out  registered strobe, one clock per completed PWM cycle
//   busy       out  1 while in RUN or DRAIN
//   fsm_state  out  2  current FSM state (ST_IDLE/ST_RUN/ST_DRAIN)
// ---------------------------------------------------------------------------
module pwm_beep_gen
    import pwm_beep_gen_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pulse,
    output logic             beep_out,
    output logic             cyc_done,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             active;
    logic             load;
    logic             wrap;
    logic             period_ok;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pulse_sh;

    assign active    = (state != ST_IDLE);
    assign period_ok = (period != '0);
    assign busy      = active;
    assign fsm_state = state;

    pwm_beep_gen_shadow_cnt #(
        .CNT_W (CNT_W)
    ) u_shadow_cnt (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .active   (active),
        .load     (load),
        .period   (period),
        .pulse    (pulse),
        .cnt      (cnt),
        .pulse_sh (pulse_sh),
        .wrap     (wrap)
    );

    // RUN and DRAIN count the same way. They differ only in what en says
    // about the next boundary. A zero period is never loaded. At a boundary
    // a zero period ends the tone just as en=0 does.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && period_ok) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (wrap) begin
                    if (en && period_ok) begin
                        load      = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = en ? ST_RUN : ST_DRAIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Both outputs are registered, so they lag cnt by one clock.
    // pulse_sh >= period_sh holds beep_out high for the whole cycle.
    // pulse_sh == 0 holds beep_out low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beep_out <= 1'b0;
            cyc_done <= 1'b0;
        end else begin
            beep_out <= active && (cnt < pulse_sh);
            cyc_done <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_beep_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_beep_gen
//   Directed bench for pwm_beep_gen. Inputs change on the falling edge and
//   outputs are sampled there. Step s is the s-th falling edge after the
//   tone request. From step 2 onward, beep_out shows counter position s-2.
// ---------------------------------------------------------------------------
module tb_pwm_beep_gen;

    localparam int CNT_W = 26;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse;
    logic             beep_out;
    logic             cyc_done;
    logic             busy;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_beep_gen #(
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .period    (period),
        .pulse     (pulse),
        .beep_out  (beep_out),
        .cyc_done  (cyc_done),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        sys_rst_n = 1'b0;
        en        = 1'b0;
        period    = '0;
        pulse     = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic start_tone(input int p, input int q);
        en     = 1'b1;
        period = CNT_W'(p);
        pulse  = CNT_W'(q);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst_n = 1'b0;
        en        = 1'b1;
        period    = 26'd30;
        pulse     = 26'd15;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({beep_out, cyc_done, busy, fsm_state} !== 5'b00000)
            $display("FAIL reset_hold: got %b expected 00000", {beep_out, cyc_done, busy, fsm_state});
        else n_pass++;
        do_reset();
        n_checks++;
        if ({beep_out, cyc_done, busy, fsm_state} !== 5'b00000)
            $display("FAIL reset_release: got %b expected 00000", {beep_out, cyc_done, busy, fsm_state});
        else n_pass++;
    endtask

    // 30/15: 15 high, 15 low, cyc_done on cycle position 29.
    task automatic test_steady();
        logic [2:0] exp;
        do_reset();
        start_tone(30, 15);
        for (int s = 1; s <= 65; s++) begin
            @(negedge sys_clk);
            exp[2] = (s >= 2) && (((s - 2) % 30) < 15);
            exp[1] = (s >= 2) && (((s - 2) % 30) == 29);
            exp[0] = 1'b1;
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL steady s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
        end
    endtask

    // Switch to 20/10 while the counter is at 7. The 30/15 cycle finishes,
    // and 20/10 cycles start at step 32.
    task automatic test_retune();
        logic [2:0] exp;
        int ph;
        do_reset();
        start_tone(30, 15);
        for (int s = 1; s <= 75; s++) begin
            @(negedge sys_clk);
            if (s < 32) begin
                ph     = s - 2;
                exp[2] = (s >= 2) && (ph < 15);
                exp[1] = (s == 31);
            end else begin
                ph     = (s - 32) % 20;
                exp[2] = (ph < 10);
                exp[1] = (ph == 19);
            end
            exp[0] = 1'b1;
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL retune s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
            if (s == 8) begin
                period = 26'd20;
                pulse  = 26'd10;
            end
        end
    endtask

    // Drop en at counter 3. The cycle completes and then the FSM goes idle.
    task automatic test_drain();
        logic [2:0] exp;
        do_reset();
        start_tone(30, 15);
        for (int s = 1; s <= 40; s++) begin
            @(negedge sys_clk);
            exp[2] = (s >= 2) && (s <= 16);
            exp[1] = (s == 31);
            exp[0] = (s <= 30);
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL drain s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
            if (s == 10) begin
                n_checks++;
                if (fsm_state !== S_DRAIN)
                    $display("FAIL drain_state: got %0d expected %0d", fsm_state, S_DRAIN);
                else n_pass++;
            end
            if (s == 4) en = 1'b0;
        end
    endtask

    // Drop en at counter 3 and raise it again at counter 20. The tone goes on
    // exactly as if en had never dropped.
    task automatic test_drain_resume();
        logic [2:0] exp;
        do_reset();
        start_tone(30, 15);
        for (int s = 1; s <= 70; s++) begin
            @(negedge sys_clk);
            exp[2] = (s >= 2) && (((s - 2) % 30) < 15);
            exp[1] = (s >= 2) && (((s - 2) % 30) == 29);
            exp[0] = 1'b1;
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL resume s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
            if (s == 10) begin
                n_checks++;
                if (fsm_state !== S_DRAIN)
                    $display("FAIL resume_state: got %0d expected %0d", fsm_state, S_DRAIN);
                else n_pass++;
            end
            if (s == 4)  en = 1'b0;
            if (s == 21) en = 1'b1;
        end
    endtask

    // pulse > period gives a constant high. pulse == 0 gives a constant low,
    // and cyc_done keeps pulsing in both cases.
    task automatic test_pulse_limits();
        logic [2:0] exp;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            start_tone(30, (k == 0) ? 40 : 0);
            for (int s = 1; s <= 62; s++) begin
                @(negedge sys_clk);
                exp[2] = (k == 0) && (s >= 2);
                exp[1] = (s >= 2) && (((s - 2) % 30) == 29);
                exp[0] = 1'b1;
                n_checks++;
                if ({beep_out, cyc_done, busy} !== exp)
                    $display("FAIL pulse_limit k=%0d s=%0d: got beep/cyc/busy %b expected %b", k, s, {beep_out, cyc_done, busy}, exp);
                else n_pass++;
            end
        end
    endtask

    // period = 1: every clock is a wrap.
    task automatic test_period_one();
        logic [2:0] exp;
        do_reset();
        start_tone(1, 1);
        for (int s = 1; s <= 8; s++) begin
            @(negedge sys_clk);
            exp = {(s >= 2), (s >= 2), 1'b1};
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL period_one s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
        end
    endtask

    // period = 0 blocks a start, and it ends a running tone at the next wrap.
    task automatic test_period_zero();
        logic [2:0] exp;
        do_reset();
        start_tone(0, 15);
        for (int s = 1; s <= 10; s++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({beep_out, cyc_done, busy, fsm_state} !== 5'b00000)
                $display("FAIL zero_start s=%0d: got %b expected 00000", s, {beep_out, cyc_done, busy, fsm_state});
            else n_pass++;
        end
        do_reset();
        start_tone(30, 15);
        for (int s = 1; s <= 40; s++) begin
            @(negedge sys_clk);
            exp[2] = (s >= 2) && (s <= 16);
            exp[1] = (s == 31);
            exp[0] = (s <= 30);
            n_checks++;
            if ({beep_out, cyc_done, busy} !== exp)
                $display("FAIL zero_run s=%0d: got beep/cyc/busy %b expected %b", s, {beep_out, cyc_done, busy}, exp);
            else n_pass++;
            if (s == 10) period = '0;
        end
    endtask

    // Reset while the tone is high at counter 12. The outputs drop at once,
    // and the tone restarts from IDLE after release.
    task automatic test_reset_mid_tone();
        do_reset();
        start_tone(30, 15);
        repeat (14) @(negedge sys_clk);
        n_checks++;
        if (beep_out !== 1'b1)
            $display("FAIL pre_reset_high: got %b expected 1", beep_out);
        else n_pass++;
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({beep_out, cyc_done, busy, fsm_state} !== 5'b00000)
            $display("FAIL async_reset: got %b expected 00000", {beep_out, cyc_done, busy, fsm_state});
        else n_pass++;
        for (int s = 1; s <= 3; s++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({beep_out, cyc_done, busy, fsm_state} !== 5'b00000)
                $display("FAIL reset_hold_mid s=%0d: got %b expected 00000", s, {beep_out, cyc_done, busy, fsm_state});
            else n_pass++;
        end
        sys_rst_n = 1'b1;
        #1;
        n_checks++;
        if (fsm_state !== S_IDLE)
            $display("FAIL post_reset_idle: got %0d expected %0d", fsm_state, S_IDLE);
        else n_pass++;
        @(negedge sys_clk);
        n_checks++;
        if ({beep_out, busy} !== 2'b01)
            $display("FAIL post_reset_s1: got beep/busy %b expected 01", {beep_out, busy});
        else n_pass++;
        @(negedge sys_clk);
        n_checks++;
        if ({beep_out, busy} !== 2'b11)
            $display("FAIL post_reset_s2: got beep/busy %b expected 11", {beep_out, busy});
        else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        sys_rst_n = 1'b0;
        en        = 1'b0;
        period    = '0;
        pulse     = '0;
        @(negedge sys_clk);
        test_reset();
        test_steady();
        test_retune();
        test_drain();
        test_drain_resume();
        test_pulse_limits();
        test_period_one();
        test_period_zero();
        test_reset_mid_tone();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
